// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: control word, opcode map and the decode helpers.
// COP0 opcodes are decoded outside this package (see decode_queue_cop0_decoder).
package decode_queue_pkg;

    localparam int unsigned INSTR_W = 32;

    // Main opcode field, instr[31:26]
    localparam logic [5:0] OPC_RTYPE    = 6'h00;
    localparam logic [5:0] OPC_REGIMM   = 6'h01;
    localparam logic [5:0] OPC_J        = 6'h02;
    localparam logic [5:0] OPC_JAL      = 6'h03;
    localparam logic [5:0] OPC_BEQ      = 6'h04;
    localparam logic [5:0] OPC_BNE      = 6'h05;
    localparam logic [5:0] OPC_BLEZ     = 6'h06;
    localparam logic [5:0] OPC_BGTZ     = 6'h07;
    localparam logic [5:0] OPC_ADDI     = 6'h08;
    localparam logic [5:0] OPC_ADDIU    = 6'h09;
    localparam logic [5:0] OPC_SLTI     = 6'h0a;
    localparam logic [5:0] OPC_SLTIU    = 6'h0b;
    localparam logic [5:0] OPC_ANDI     = 6'h0c;
    localparam logic [5:0] OPC_ORI      = 6'h0d;
    localparam logic [5:0] OPC_XORI     = 6'h0e;
    localparam logic [5:0] OPC_LUI      = 6'h0f;
    localparam logic [5:0] OPC_COP0     = 6'h10;
    localparam logic [5:0] OPC_BEQL     = 6'h14;
    localparam logic [5:0] OPC_BNEL     = 6'h15;
    localparam logic [5:0] OPC_BLEZL    = 6'h16;
    localparam logic [5:0] OPC_BGTZL    = 6'h17;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1c;
    localparam logic [5:0] OPC_LB       = 6'h20;
    localparam logic [5:0] OPC_LH       = 6'h21;
    localparam logic [5:0] OPC_LW       = 6'h23;
    localparam logic [5:0] OPC_LBU      = 6'h24;
    localparam logic [5:0] OPC_LHU      = 6'h25;
    localparam logic [5:0] OPC_SB       = 6'h28;
    localparam logic [5:0] OPC_SH       = 6'h29;
    localparam logic [5:0] OPC_SW       = 6'h2b;

    // RTYPE funct field, instr[5:0]
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [5:0] FN_BREAK   = 6'h0d;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2a;
    localparam logic [5:0] FN_SLTU    = 6'h2b;
    localparam logic [5:0] FN2_MUL    = 6'h02;

    // COP0 rs field and the fixed low bits of ERET
    localparam logic [4:0]  COP0_MF   = 5'h00;
    localparam logic [4:0]  COP0_MT   = 5'h04;
    localparam logic [25:0] COP0_ERET = 26'h2000018;

    typedef enum logic [1:0] {OPD_NONE, OPD_RS, OPD_RT, OPD_RS_RT} opd_use_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MUL
    } alu_op_t;
    typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ} branch_t;
    typedef enum logic [1:0] {REG_DST_RD, REG_DST_RT, REG_DST_RA} reg_dst_t;
    typedef enum logic [2:0] {
        REG_SRC_ALU, REG_SRC_MEM, REG_SRC_PC8, REG_SRC_HI, REG_SRC_LO, REG_SRC_COP0
    } reg_src_t;
    typedef enum logic [3:0] {
        MEM_NONE, MEM_READ_BYTE, MEM_READ_HALF, MEM_READ_WORD, MEM_READ_BYTE_U,
        MEM_READ_HALF_U, MEM_WRITE_BYTE, MEM_WRITE_HALF, MEM_WRITE_WORD
    } mem_op_t;
    typedef enum logic [2:0] {
        PC_SRC_NEXT, PC_SRC_JUMP, PC_SRC_JREG, PC_SRC_BRANCH, PC_SRC_EXECPTION, PC_SRC_ERET
    } pc_src_t;
    typedef enum logic [2:0] {
        EXC_CHK_NONE, EXC_CHK_OVERFLOW, EXC_CHK_SYSCALL, EXC_CHK_BREAK, EXC_CHK_RESERVERD
    } exc_chk_t;

    typedef struct packed {
        opd_use_t opd_use;
        alu_op_t  alu_op;
        logic     alu_imm;
        logic     imm_zext;
        branch_t  branch;
        logic     likely;
        reg_dst_t reg_dst;
        reg_src_t reg_src;
        logic     write_reg;
        mem_op_t  mem_op;
        logic     write_mem;
        logic     write_cop0;
        pc_src_t  pc_src;
        exc_chk_t exc_chk;
    } control_t;

    // Control word of an instruction with no architectural effect
    function automatic control_t nop_control();
        control_t c;
        c.opd_use    = OPD_NONE;
        c.alu_op     = ALU_ADD;
        c.alu_imm    = 1'b0;
        c.imm_zext   = 1'b0;
        c.branch     = BR_NONE;
        c.likely     = 1'b0;
        c.reg_dst    = REG_DST_RD;
        c.reg_src    = REG_SRC_ALU;
        c.write_reg  = 1'b0;
        c.mem_op     = MEM_NONE;
        c.write_mem  = 1'b0;
        c.write_cop0 = 1'b0;
        c.pc_src     = PC_SRC_NEXT;
        c.exc_chk    = EXC_CHK_NONE;
        return c;
    endfunction

    function automatic control_t reserved_control();
        control_t c;
        c         = nop_control();
        c.pc_src  = PC_SRC_EXECPTION;
        c.exc_chk = EXC_CHK_RESERVERD;
        return c;
    endfunction

    function automatic control_t rtype_control(input logic [5:0] funct);
        control_t c;
        c           = nop_control();
        c.opd_use   = OPD_RS_RT;
        c.write_reg = 1'b1;
        c.reg_dst   = REG_DST_RD;
        case (funct)
            FN_SLL:  begin c.opd_use = OPD_RT; c.alu_op = ALU_SLL; end
            FN_SRL:  begin c.opd_use = OPD_RT; c.alu_op = ALU_SRL; end
            FN_SRA:  begin c.opd_use = OPD_RT; c.alu_op = ALU_SRA; end
            FN_SLLV: c.alu_op = ALU_SLL;
            FN_SRLV: c.alu_op = ALU_SRL;
            FN_SRAV: c.alu_op = ALU_SRA;
            FN_JR: begin
                c.opd_use   = OPD_RS;
                c.write_reg = 1'b0;
                c.pc_src    = PC_SRC_JREG;
            end
            FN_JALR: begin
                c.opd_use = OPD_RS;
                c.reg_src = REG_SRC_PC8;
                c.pc_src  = PC_SRC_JREG;
            end
            FN_SYSCALL: begin
                c         = nop_control();
                c.pc_src  = PC_SRC_EXECPTION;
                c.exc_chk = EXC_CHK_SYSCALL;
            end
            FN_BREAK: begin
                c         = nop_control();
                c.pc_src  = PC_SRC_EXECPTION;
                c.exc_chk = EXC_CHK_BREAK;
            end
            FN_MFHI: begin c.opd_use = OPD_NONE; c.reg_src = REG_SRC_HI; end
            FN_MFLO: begin c.opd_use = OPD_NONE; c.reg_src = REG_SRC_LO; end
            FN_ADD:  begin c.alu_op = ALU_ADD; c.exc_chk = EXC_CHK_OVERFLOW; end
            FN_ADDU: c.alu_op = ALU_ADD;
            FN_SUB:  begin c.alu_op = ALU_SUB; c.exc_chk = EXC_CHK_OVERFLOW; end
            FN_SUBU: c.alu_op = ALU_SUB;
            FN_AND:  c.alu_op = ALU_AND;
            FN_OR:   c.alu_op = ALU_OR;
            FN_XOR:  c.alu_op = ALU_XOR;
            FN_NOR:  c.alu_op = ALU_NOR;
            FN_SLT:  c.alu_op = ALU_SLT;
            FN_SLTU: c.alu_op = ALU_SLTU;
            default: c = reserved_control();
        endcase
        return c;
    endfunction

    // rt selects the condition; bit 1 marks likely, bit 4 marks link
    function automatic control_t regimm_control(input logic [4:0] rt);
        control_t c;
        c = nop_control();
        if (rt[3:2] == 2'b00 && (rt[4] == 1'b0 || rt[1] == 1'b0)) begin
            c.opd_use = OPD_RS;
            c.branch  = rt[0] ? BR_GEZ : BR_LTZ;
            c.likely  = rt[1];
            c.pc_src  = PC_SRC_BRANCH;
            if (rt[4]) begin
                c.write_reg = 1'b1;
                c.reg_dst   = REG_DST_RA;
                c.reg_src   = REG_SRC_PC8;
            end
        end else begin
            c = reserved_control();
        end
        return c;
    endfunction

    function automatic control_t special2_control(input logic [5:0] funct);
        control_t c;
        c = reserved_control();
        if (funct == FN2_MUL) begin
            c           = nop_control();
            c.opd_use   = OPD_RS_RT;
            c.alu_op    = ALU_MUL;
            c.write_reg = 1'b1;
        end
        return c;
    endfunction

    function automatic control_t imm_control(input alu_op_t op, input logic zext);
        control_t c;
        c           = nop_control();
        c.opd_use   = OPD_RS;
        c.alu_op    = op;
        c.alu_imm   = 1'b1;
        c.imm_zext  = zext;
        c.write_reg = 1'b1;
        c.reg_dst   = REG_DST_RT;
        return c;
    endfunction

    function automatic control_t load_control(input mem_op_t m);
        control_t c;
        c         = imm_control(ALU_ADD, 1'b0);
        c.reg_src = REG_SRC_MEM;
        c.mem_op  = m;
        return c;
    endfunction

    function automatic control_t store_control(input mem_op_t m);
        control_t c;
        c           = imm_control(ALU_ADD, 1'b0);
        c.opd_use   = OPD_RS_RT;
        c.write_reg = 1'b0;
        c.write_mem = 1'b1;
        c.mem_op    = m;
        return c;
    endfunction

    // Everything except COP0, which decodes as reserved here
    function automatic control_t decode_instr(input logic [INSTR_W-1:0] instr);
        control_t   c;
        logic [5:0] opc;
        opc = instr[31:26];
        c   = nop_control();
        case (opc)
            OPC_RTYPE:    c = rtype_control(instr[5:0]);
            OPC_REGIMM:   c = regimm_control(instr[20:16]);
            OPC_SPECIAL2: c = special2_control(instr[5:0]);
            OPC_J:        c.pc_src = PC_SRC_JUMP;
            OPC_JAL: begin
                c.pc_src    = PC_SRC_JUMP;
                c.write_reg = 1'b1;
                c.reg_dst   = REG_DST_RA;
                c.reg_src   = REG_SRC_PC8;
            end
            OPC_BEQ, OPC_BNE, OPC_BEQL, OPC_BNEL: begin
                c.opd_use = OPD_RS_RT;
                c.branch  = opc[0] ? BR_NE : BR_EQ;
                c.likely  = opc[4];
                c.pc_src  = PC_SRC_BRANCH;
            end
            OPC_BLEZ, OPC_BGTZ, OPC_BLEZL, OPC_BGTZL: begin
                c.opd_use = OPD_RS;
                c.branch  = opc[0] ? BR_GTZ : BR_LEZ;
                c.likely  = opc[4];
                c.pc_src  = PC_SRC_BRANCH;
            end
            OPC_ADDI: begin
                c         = imm_control(ALU_ADD, 1'b0);
                c.exc_chk = EXC_CHK_OVERFLOW;
            end
            OPC_ADDIU: c = imm_control(ALU_ADD, 1'b0);
            OPC_SLTI:  c = imm_control(ALU_SLT, 1'b0);
            OPC_SLTIU: c = imm_control(ALU_SLTU, 1'b0);
            OPC_ANDI:  c = imm_control(ALU_AND, 1'b1);
            OPC_ORI:   c = imm_control(ALU_OR, 1'b1);
            OPC_XORI:  c = imm_control(ALU_XOR, 1'b1);
            OPC_LUI: begin
                c         = imm_control(ALU_LUI, 1'b1);
                c.opd_use = OPD_NONE;
            end
            OPC_LB:  c = load_control(MEM_READ_BYTE);
            OPC_LH:  c = load_control(MEM_READ_HALF);
            OPC_LW:  c = load_control(MEM_READ_WORD);
            OPC_LBU: c = load_control(MEM_READ_BYTE_U);
            OPC_LHU: c = load_control(MEM_READ_HALF_U);
            OPC_SB:  c = store_control(MEM_WRITE_BYTE);
            OPC_SH:  c = store_control(MEM_WRITE_HALF);
            OPC_SW:  c = store_control(MEM_WRITE_WORD);
            default: c = reserved_control();
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_queue_cop0_decoder.sv
// COP0 instruction decoder (MFC0, MTC0, ERET); only built when DECODE_QUEUE_COP0_EN is defined.
`ifdef DECODE_QUEUE_COP0_EN
module decode_queue_cop0_decoder
    import decode_queue_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output control_t           ctl_c_o
);

    always_comb begin
        ctl_c_o = reserved_control();
        if (instr_i[31:26] == OPC_COP0) begin
            if (instr_i[25:21] == COP0_MF) begin
                ctl_c_o           = nop_control();
                ctl_c_o.write_reg = 1'b1;
                ctl_c_o.reg_dst   = REG_DST_RT;
                ctl_c_o.reg_src   = REG_SRC_COP0;
            end else if (instr_i[25:21] == COP0_MT) begin
                ctl_c_o            = nop_control();
                ctl_c_o.opd_use    = OPD_RT;
                ctl_c_o.write_cop0 = 1'b1;
            end else if (instr_i[25:0] == COP0_ERET) begin
                ctl_c_o        = nop_control();
                ctl_c_o.pc_src = PC_SRC_ERET;
            end
        end
    end

endmodule
`endif

// File: rtl/decode_queue.sv
// Decode queue between fetch and register read: decodes on enqueue, buffers DEPTH entries.
// Define DECODE_QUEUE_COP0_EN to decode COP0 instead of trapping it as reserved.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [PC_W-1:0]              in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [PC_W-1:0]              out_pc,
    output control_t                     out_ctl,
    output logic                         out_annulled,
    input  logic                         annul,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [PC_W-1:0]    pc_q    [DEPTH];
    control_t           ctl_q   [DEPTH];
    logic [DEPTH-1:0]   ann_q;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic     enq;
    logic     deq;
    logic     ann_hit;
    control_t dec_ctl;

`ifdef DECODE_QUEUE_COP0_EN
    control_t cop0_ctl;

    decode_queue_cop0_decoder u_cop0_decoder (
        .instr_i (in_instr),
        .ctl_c_o (cop0_ctl)
    );

    assign dec_ctl = (in_instr[31:26] == OPC_COP0) ? cop0_ctl : decode_instr(in_instr);
`else
    assign dec_ctl = decode_instr(in_instr);
`endif

    // in_ready looks only at count so out_ready never reaches it combinationally
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign enq     = in_valid & in_ready & ~flush & ~reset;
    assign deq     = out_valid & out_ready & ~flush & ~reset;
    assign ann_hit = annul & out_valid & ~flush & ~reset;

    // Annul is the only input that reaches the outputs combinationally
    assign out_instr    = instr_q[head_q];
    assign out_pc       = pc_q[head_q];
    assign out_annulled = out_valid & (ann_q[head_q] | annul);
    assign out_ctl      = out_annulled ? nop_control() : ctl_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_W'(1);
            if (deq) head_d = head_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is never reset; head==tail only when empty or full, so the two writes never collide
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_q[tail_q] <= in_instr;
            pc_q[tail_q]    <= in_pc;
            ctl_q[tail_q]   <= dec_ctl;
            ann_q[tail_q]   <= 1'b0;
        end
        if (ann_hit) begin
            ann_q[head_q] <= 1'b1;
            ctl_q[head_q] <= nop_control();
        end
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised instruction decode queue between fetch and the register-read stage. Accepts fetched instruction/PC pairs over a valid/ready handshake and decodes each one on enqueue into a `signals::control_t` word. Buffers up to DEPTH decoded entries and presents the head to the next stage through a second valid/ready handshake. It adds flush, branch-likely delay-slot annulment and an optional COP0 decode path.

## Interface
- DEPTH, 4: entry count; power of two, at least 2.
- PC_W, 32: width of the PC carried with each entry.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  reset; synchronous, active-high.
- flush  in  1  discard every entry (pipeline redirect).
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  queue accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction address.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer takes the head.
- out_instr  out  32  head instruction.
- out_pc  out  PC_W  head PC.
- out_ctl  out  control_t  head decoded control.
- out_annulled  out  1  head was annulled.
- annul  in  1  annul the current head (branch-likely not taken).
- count  out  $clog2(DEPTH+1)  occupancy.

## Operation
- Storage is a circular buffer with a head pointer, a tail pointer (each $clog2(DEPTH) bits, wrapping naturally) and a separate occupancy counter.
- Each entry holds {instr, pc, ctl, annulled}.
- Enqueue occurs when in_valid && in_ready.
  - ctl is computed combinationally from in_instr, then stored.
  - annulled is stored as 0.
- Decode:
  - RTYPE, REGIMM and SPECIAL2 opcodes use the existing sub-decoders.
  - J/JAL, branches (including the -L forms), ADDI/ADDIU, SLTI/SLTIU, ANDI/ORI/XORI, LB/LH/LW, SW and LUI use the existing control encodings.
  - This block adds LBU and LHU: `MEM_READ_BYTE_U` / `MEM_READ_HALF_U`, destination rt.
  - This block adds SB and SH: `MEM_WRITE_BYTE` / `MEM_WRITE_HALF`, `write_mem`=1.
  - Any other opcode gives opd_use NONE, pc_src `PC_SRC_EXECPTION`, exc_chk `EXC_CHK_RESERVERD`.
- Dequeue occurs when out_valid && out_ready.
- in_ready = (count != DEPTH). A full queue does not accept even when a dequeue happens in the same cycle; this keeps timing off the consumer path.
- out_valid = (count != 0). The out_* fields always show the head entry.
- Annul:
  - If annul && out_valid, the head's annulled bit is set and its stored ctl is replaced by the default (NOP) control.
  - If out_ready is also high, the head leaves in that cycle. The annulled version is what appears on out_* combinationally.
  - If annul is high while out_valid is low, it is ignored.
  - Annul on an entry that is already annulled has no further effect.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Flush:
  - Clears count and both pointers.
  - Has priority over enqueue, dequeue and annul in the same cycle; the entry offered that cycle is dropped.
  - in_ready may be high during flush, but the handshake has no effect.
- Reset: same effect as flush. Entry payload RAM is not cleared.

## Timing
- Reset values: count=0, out_valid=0, in_ready=1, out_annulled=0. out_instr, out_pc and out_ctl show stale payload and must be qualified by out_valid.
- Latency: an entry enqueued on edge N is visible at the output after N, i.e. in cycle N+1. There is no same-cycle bypass.
- Throughput: one enqueue and one dequeue per cycle.
- in_ready depends only on count, so there is no combinational path from out_ready to in_ready.
- out_* depend only on registers plus annul, the only input-to-output combinational path.
- Reset or flush asserted mid-stream takes effect at the next edge. From the following cycle out_valid=0 and in_ready=1.

## Configuration
- `DECODE_QUEUE_COP0_EN` defined: opcode COP0 is decoded.
  - MFC0: `write_rt`, reg_src `REG_SRC_COP0`.
  - MTC0: opd_use RT, `write_cop0`=1.
  - ERET: pc_src `PC_SRC_ERET`.
  - Any other COP0 rs field is a reserved-instruction exception.
- `DECODE_QUEUE_COP0_EN` not defined: COP0 decodes as a reserved-instruction exception, like every other unknown opcode.

## Structure
- Package `signals`/`selector` gains `REG_SRC_COP0`, `PC_SRC_ERET`, `MEM_READ_BYTE_U`, `MEM_READ_HALF_U`, `MEM_WRITE_BYTE`, `MEM_WRITE_HALF` and the control_t field `write_cop0`.
- Package `main_opcode` gains LBU, LHU, SB, SH and COP0.
- `decoder_util` gains a `nop_control()` function used by annul.
- Sub-module `cop0_decoder` (instruction → control_t), instantiated only under `DECODE_QUEUE_COP0_EN`.

## Test plan
- Reset, then enqueue ADDIU $t0,$zero,5 (0x24080005) at pc 0x400 → the following cycle out_valid=1, out_pc=0x400, out_ctl.write_reg=1, exc_chk none, count=1.
- Enqueue DEPTH entries with out_ready=0 → in_ready drops after the 4th. A 5th offer is held, count=4. Raise out_ready → entries drain in order, pointers wrap, count returns to 0.
- Hold in_valid and out_ready high with pc incrementing by 4 for 20 cycles → one entry per cycle, no loss, count constant at 1.
- BEQL then its delay slot; assert annul while the delay slot is at the head → out_annulled=1, out_ctl.write_reg=0, write_mem=0.
- Fill to 3, then flush together with in_valid → next cycle count=0, out_valid=0, and the offered entry is absent.
- Enqueue 0x42000018 (ERET) → with the macro, pc_src=`PC_SRC_ERET`; without it, exc_chk=`EXC_CHK_RESERVERD`.
